overlay_param_arbiter: RTL and testbench

OVERLAY_PARAM_ARBITER -- requirements
Module: overlay_param_arbiter

---
 rtl/display_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/overlay_param_arbiter.sv | 157 +++++++++++++++
 tb/tb_overlay_param_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the overlay display path: object indices,
// field widths, power-up parameter defaults and the arbiter FSM states.
package display_pkg;

  localparam int OBJ_BALL    = 0;
  localparam int OBJ_TARGET  = 1;
  localparam int OBJ_VIRTUAL = 2;

  localparam int H_W = 11;
  localparam int V_W = 10;
  localparam int R_W = 11;

  localparam logic [H_W-1:0] DEF_H = 11'd512;
  localparam logic [V_W-1:0] DEF_V = 10'd384;
  localparam logic [R_W-1:0] DEF_R = 11'd20;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_COMMIT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant starting the search at
// the pointer, pointer advances past the winner on every grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (en_i && !found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        ptr_d        = PW'((idx + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/overlay_param_arbiter.sv
// Collects overlay parameter updates from several requesters into shadow
// registers and commits them to the active set once per frame at vsync.
module overlay_param_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_OBJ = 3
) (
  input  logic                          vclock_in,
  input  logic                          reset_in,
  input  logic                          vsync_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic [NUM_REQ-1:0][1:0]       req_obj_in,
  input  logic [NUM_REQ-1:0][H_W-1:0]   req_h_in,
  input  logic [NUM_REQ-1:0][V_W-1:0]   req_v_in,
  input  logic [NUM_REQ-1:0][R_W-1:0]   req_radius_in,
  output logic [NUM_OBJ-1:0][H_W-1:0]   h_center_out,
  output logic [NUM_OBJ-1:0][V_W-1:0]   v_center_out,
  output logic [NUM_OBJ-1:0][R_W-1:0]   radius_out,
  output logic [NUM_OBJ-1:0]            pending_out,
  output logic                          commit_pulse_out,
  output logic [7:0]                    bad_obj_count_out
);

  arb_state_e state_q;
  logic       vs_q;
  logic       mask_q;
  logic       pulse_q;

  logic [NUM_OBJ-1:0][H_W-1:0] act_h_q, act_h_d, sh_h_q, sh_h_d;
  logic [NUM_OBJ-1:0][V_W-1:0] act_v_q, act_v_d, sh_v_q, sh_v_d;
  logic [NUM_OBJ-1:0][R_W-1:0] act_r_q, act_r_d, sh_r_q, sh_r_d;
  logic [NUM_OBJ-1:0]          pend_q, pend_d;
  logic [7:0]                  bad_q, bad_d;

  logic [NUM_REQ-1:0] grant;
  logic               wr_valid;
  logic [1:0]         sel_obj;
  logic [H_W-1:0]     sel_h;
  logic [V_W-1:0]     sel_v;
  logic [R_W-1:0]     sel_r;
  logic               edge_det;

  // mask_q suppresses a false edge right after reset release, since vs_q resets high
  assign edge_det = vs_q && !vsync_in && !mask_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i   (vclock_in),
    .rst_ni  (reset_in),
    .en_i    (reset_in && (state_q == ST_ACCEPT)),
    .valid_i (req_valid_in),
    .grant_o (grant)
  );

  assign req_ready_out = grant;
  assign wr_valid      = |grant;

  always_comb begin
    sel_obj = '0;
    sel_h   = '0;
    sel_v   = '0;
    sel_r   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_obj = req_obj_in[i];
        sel_h   = req_h_in[i];
        sel_v   = req_v_in[i];
        sel_r   = req_radius_in[i];
      end
    end
  end

  always_comb begin
    act_h_d = act_h_q;
    act_v_d = act_v_q;
    act_r_d = act_r_q;
    sh_h_d  = sh_h_q;
    sh_v_d  = sh_v_q;
    sh_r_d  = sh_r_q;
    pend_d  = pend_q;
    bad_d   = bad_q;
    if (state_q == ST_COMMIT) begin
      for (int o = 0; o < NUM_OBJ; o++) begin
        if (pend_q[o]) begin
          act_h_d[o] = sh_h_q[o];
          act_v_d[o] = sh_v_q[o];
          act_r_d[o] = sh_r_q[o];
        end
      end
      pend_d = '0;
    end else if (wr_valid) begin
      if (int'(sel_obj) < NUM_OBJ) begin
        for (int o = 0; o < NUM_OBJ; o++) begin
          if (int'(sel_obj) == o) begin
            sh_h_d[o] = sel_h;
            sh_v_d[o] = sel_v;
            sh_r_d[o] = sel_r;
            pend_d[o] = 1'b1;
          end
        end
      end else if (bad_q != 8'hFF) begin
        bad_d = bad_q + 8'd1;
      end
    end
  end

  always_ff @(posedge vclock_in) begin
    if (!reset_in) begin
      state_q <= ST_ACCEPT;
      vs_q    <= 1'b1;
      mask_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      vs_q    <= vsync_in;
      mask_q  <= 1'b0;
      pulse_q <= (state_q == ST_COMMIT);
      case (state_q)
        ST_ACCEPT: if (edge_det) state_q <= ST_COMMIT;
        ST_COMMIT: state_q <= ST_ACCEPT;
        default:   state_q <= ST_ACCEPT;
      endcase
    end
  end

  always_ff @(posedge vclock_in) begin
    if (!reset_in) begin
      for (int o = 0; o < NUM_OBJ; o++) begin
        act_h_q[o] <= DEF_H;
        act_v_q[o] <= DEF_V;
        act_r_q[o] <= DEF_R;
        sh_h_q[o]  <= DEF_H;
        sh_v_q[o]  <= DEF_V;
        sh_r_q[o]  <= DEF_R;
      end
      pend_q <= '0;
      bad_q  <= '0;
    end else begin
      act_h_q <= act_h_d;
      act_v_q <= act_v_d;
      act_r_q <= act_r_d;
      sh_h_q  <= sh_h_d;
      sh_v_q  <= sh_v_d;
      sh_r_q  <= sh_r_d;
      pend_q  <= pend_d;
      bad_q   <= bad_d;
    end
  end

  assign h_center_out      = act_h_q;
  assign v_center_out      = act_v_q;
  assign radius_out        = act_r_q;
  assign pending_out       = pend_q;
  assign commit_pulse_out  = pulse_q;
  assign bad_obj_count_out = bad_q;

endmodule

// File: tb/tb_overlay_param_arbiter.sv
// Self-checking bench for overlay_param_arbiter: a cycle model predicts every
// output and a queue of expected active snapshots is matched to commit pulses.
module tb_overlay_param_arbiter;
  import display_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstN;
  logic             vsync;
  logic [1:0]       valid;
  logic [1:0]       ready;
  logic [1:0][1:0]  objIn;
  logic [1:0][10:0] hIn;
  logic [1:0][9:0]  vIn;
  logic [1:0][10:0] rIn;
  logic [2:0][10:0] hOut;
  logic [2:0][9:0]  vOut;
  logic [2:0][10:0] rOut;
  logic [2:0]       pendOut;
  logic             pulseOut;
  logic [7:0]       badOut;

  overlay_param_arbiter #(.NUM_REQ(2), .NUM_OBJ(3)) dut (
    .vclock_in         (clk),
    .reset_in          (rstN),
    .vsync_in          (vsync),
    .req_valid_in      (valid),
    .req_ready_out     (ready),
    .req_obj_in        (objIn),
    .req_h_in          (hIn),
    .req_v_in          (vIn),
    .req_radius_in     (rIn),
    .h_center_out      (hOut),
    .v_center_out      (vOut),
    .radius_out        (rOut),
    .pending_out       (pendOut),
    .commit_pulse_out  (pulseOut),
    .bad_obj_count_out (badOut)
  );

  typedef struct packed {
    logic [2:0][10:0] h;
    logic [2:0][9:0]  v;
    logic [2:0][10:0] r;
  } snap_t;

  snap_t sbQ[$];

  int checks = 0;
  int errors = 0;

  logic [2:0][10:0] mActH, mShH;
  logic [2:0][9:0]  mActV, mShV;
  logic [2:0][10:0] mActR, mShR;
  logic [2:0]       mPend;
  int               mBad;
  int               mPtr;
  logic             mState;
  logic             mVs;
  logic             mMask;
  logic             mPulse;
  logic [1:0]       lastReady;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int o = 0; o < 3; o++) begin
      mActH[o] = DEF_H; mActV[o] = DEF_V; mActR[o] = DEF_R;
      mShH[o]  = DEF_H; mShV[o]  = DEF_V; mShR[o]  = DEF_R;
    end
    mPend = '0; mBad = 0; mPtr = 0; mState = 1'b0;
    mVs = 1'b1; mMask = 1'b1; mPulse = 1'b0;
  endtask

  function automatic logic [1:0] modelReady();
    int idx;
    if (!rstN || mState) return 2'b00;
    for (int k = 0; k < 2; k++) begin
      idx = (mPtr + k) % 2;
      if (valid[idx]) return (idx == 0) ? 2'b01 : 2'b10;
    end
    return 2'b00;
  endfunction

  task automatic modelStep(input logic [1:0] grant);
    int idx;
    int ob;
    snap_t s;
    if (!rstN) begin
      modelReset();
    end else begin
      mPulse = mState;
      if (grant != 2'b00) begin
        idx  = grant[1] ? 1 : 0;
        mPtr = (idx + 1) % 2;
        ob   = int'(objIn[idx]);
        if (ob < 3) begin
          mShH[ob] = hIn[idx]; mShV[ob] = vIn[idx]; mShR[ob] = rIn[idx];
          mPend[ob] = 1'b1;
        end else if (mBad < 255) begin
          mBad++;
        end
      end
      if (mState) begin
        for (int o = 0; o < 3; o++) begin
          if (mPend[o]) begin
            mActH[o] = mShH[o]; mActV[o] = mShV[o]; mActR[o] = mShR[o];
          end
        end
        mPend = '0;
        s.h = mActH; s.v = mActV; s.r = mActR;
        sbQ.push_back(s);
        mState = 1'b0;
      end else if (mVs && !vsync && !mMask) begin
        mState = 1'b1;
      end
      mVs = vsync;
      mMask = 1'b0;
    end
  endtask

  task automatic checkRegs();
    snap_t s;
    for (int o = 0; o < 3; o++) begin
      checkOutput($sformatf("h[%0d]", o), int'(hOut[o]), int'(mActH[o]));
      checkOutput($sformatf("v[%0d]", o), int'(vOut[o]), int'(mActV[o]));
      checkOutput($sformatf("r[%0d]", o), int'(rOut[o]), int'(mActR[o]));
    end
    checkOutput("pending", int'(pendOut), int'(mPend));
    checkOutput("pulse", int'(pulseOut), int'(mPulse));
    checkOutput("badCount", int'(badOut), mBad);
    if (pulseOut) begin
      if (sbQ.size() == 0) begin
        checkOutput("sbUnexpectedCommit", 1, 0);
      end else begin
        s = sbQ.pop_front();
        for (int o = 0; o < 3; o++) begin
          checkOutput($sformatf("sbH[%0d]", o), int'(hOut[o]), int'(s.h[o]));
          checkOutput($sformatf("sbV[%0d]", o), int'(vOut[o]), int'(s.v[o]));
          checkOutput($sformatf("sbR[%0d]", o), int'(rOut[o]), int'(s.r[o]));
        end
      end
    end
  endtask

  // Each cycle: check combinational ready, step the model at the edge, then check registers
  task automatic applyStimulus(input int n);
    logic [1:0] expR;
    for (int c = 0; c < n; c++) begin
      #1;
      expR = modelReady();
      checkOutput("ready", int'(ready), int'(expR));
      lastReady = ready;
      @(posedge clk);
      modelStep(expR);
      #1;
      checkRegs();
    end
  endtask

  task automatic setReq(input int i, input int ob, input int h, input int v, input int r);
    objIn[i] = 2'(ob);
    hIn[i]   = 11'(h);
    vIn[i]   = 10'(v);
    rIn[i]   = 11'(r);
  endtask

  initial begin
    logic [1:0] seq [4];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    modelReset();
    lastReady = '0;
    rstN = 1'b0; vsync = 1'b1; valid = 2'b11;
    setReq(0, 0, 1, 2, 3);
    setReq(1, 1, 4, 5, 6);

    // Reset: defaults and no ready even with both valid
    applyStimulus(3);
    checkOutput("rstReady", int'(lastReady), 0);
    checkOutput("rstBallH", int'(hOut[0]), 512);
    checkOutput("rstBallV", int'(vOut[0]), 384);
    checkOutput("rstBallR", int'(rOut[0]), 20);

    // vsync already low at reset release must not look like a frame edge
    valid = 2'b00; vsync = 1'b0; rstN = 1'b1;
    applyStimulus(3);
    checkOutput("noEdgeAfterReset", int'(pulseOut), 0);
    vsync = 1'b1;
    applyStimulus(2);

    // Single ball update, committed two cycles after vsync falls
    valid = 2'b01; setReq(0, 0, 100, 200, 30);
    applyStimulus(1);
    valid = 2'b00;
    checkOutput("ballPending", int'(pendOut), 1);
    checkOutput("ballHeldH", int'(hOut[0]), 512);
    vsync = 1'b0;
    applyStimulus(1);
    checkOutput("noEarlyCommit", int'(hOut[0]), 512);
    applyStimulus(1);
    checkOutput("ballH", int'(hOut[0]), 100);
    checkOutput("ballV", int'(vOut[0]), 200);
    checkOutput("ballR", int'(rOut[0]), 30);
    checkOutput("ballPulse", int'(pulseOut), 1);
    checkOutput("ballPendClr", int'(pendOut), 0);
    applyStimulus(1);
    checkOutput("pulseOneCycle", int'(pulseOut), 0);
    vsync = 1'b1;
    applyStimulus(2);

    // Grant to requester 1 leaves the pointer at 0, then alternate under contention
    valid = 2'b10; setReq(1, 1, 5, 6, 7);
    applyStimulus(1);
    valid = 2'b11; setReq(0, 2, 40, 41, 42); setReq(1, 2, 41, 43, 44);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("rrGrant%0d", k), int'(lastReady), int'(seq[k]));
    end
    valid = 2'b00;

    // Last write to the same object wins
    valid = 2'b01; setReq(0, 1, 10, 11, 12);
    applyStimulus(1);
    setReq(0, 1, 20, 21, 22);
    applyStimulus(1);
    valid = 2'b00; vsync = 1'b0;
    applyStimulus(2);
    checkOutput("targetLastWins", int'(hOut[1]), 20);
    checkOutput("ballKept", int'(hOut[0]), 100);
    checkOutput("virtualH", int'(hOut[2]), 41);
    vsync = 1'b1;
    applyStimulus(2);

    // Write in the edge cycle commits now; a COMMIT-cycle request waits a frame
    vsync = 1'b0; valid = 2'b01; setReq(0, 2, 300, 301, 302);
    applyStimulus(1);
    checkOutput("edgeWriteReady", int'(lastReady), 1);
    valid = 2'b10; setReq(1, 2, 77, 78, 79);
    applyStimulus(1);
    checkOutput("commitReadyLow", int'(lastReady), 0);
    checkOutput("edgeWriteCommitted", int'(hOut[2]), 300);
    applyStimulus(1);
    checkOutput("lateReady", int'(lastReady), 2);
    checkOutput("latePending", int'(pendOut), 4);
    checkOutput("lateNotYetActive", int'(hOut[2]), 300);
    valid = 2'b00; vsync = 1'b1;
    applyStimulus(2);
    vsync = 1'b0;
    applyStimulus(2);
    checkOutput("lateCommitted", int'(hOut[2]), 77);
    vsync = 1'b1;
    applyStimulus(2);

    // Invalid object index saturates the error counter and touches nothing else
    valid = 2'b01; setReq(0, 3, 999, 999, 999);
    applyStimulus(260);
    valid = 2'b00;
    checkOutput("badSaturated", int'(badOut), 255);
    checkOutput("badNoPending", int'(pendOut), 0);
    vsync = 1'b0;
    applyStimulus(2);
    checkOutput("badBallKept", int'(hOut[0]), 100);
    vsync = 1'b1;
    applyStimulus(2);

    // Reset during COMMIT overrides the commit
    valid = 2'b01; setReq(0, 0, 600, 601, 602);
    applyStimulus(1);
    valid = 2'b00; vsync = 1'b0;
    applyStimulus(1);
    rstN = 1'b0;
    applyStimulus(1);
    checkOutput("rstCommitH0", int'(hOut[0]), 512);
    checkOutput("rstCommitV1", int'(vOut[1]), 384);
    checkOutput("rstCommitR2", int'(rOut[2]), 20);
    checkOutput("rstCommitPulse", int'(pulseOut), 0);
    checkOutput("rstCommitPend", int'(pendOut), 0);
    checkOutput("rstCommitBad", int'(badOut), 0);
    rstN = 1'b1; vsync = 1'b1;
    applyStimulus(2);

    checkOutput("sbDrained", sbQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
